// File: rtl/decode_stage.sv
// ID stage: decodes the IF/ID instruction, bypasses same-cycle writeback data,
// detects load-use hazards and registers the ID/EX pipeline latch.
module decode_stage #(
  parameter int unsigned DW = 16,
  parameter int unsigned RA = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  input  logic [DW-1:0] if_instr,
  input  logic [DW-1:0] if_pc,
  input  logic          flush,
  output logic [RA-1:0] rf_raddr1,
  output logic [RA-1:0] rf_raddr2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  input  logic          wb_reg_write,
  input  logic [RA-1:0] wb_write_reg,
  input  logic [DW-1:0] wb_write_data,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_rdata1,
  output logic [DW-1:0] ex_rdata2,
  output logic [DW-1:0] ex_imm,
  output logic [RA-1:0] ex_rs,
  output logic [RA-1:0] ex_rt,
  output logic [RA-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_alu_src,
  output logic          ex_branch,
  output logic [2:0]    ex_alu_op,
  output logic          ex_illegal
);

  typedef enum logic [3:0] {
    OpRtype = 4'd0,
    OpAddi  = 4'd1,
    OpLw    = 4'd2,
    OpSw    = 4'd3,
    OpBeq   = 4'd4
  } opcode_e;

  logic [3:0]    op;
  logic [RA-1:0] rs, rt, rd;
  logic [2:0]    funct;
  logic [DW-1:0] imm;

  assign op    = if_instr[15:12];
  assign rs    = if_instr[11:9];
  assign rt    = if_instr[8:6];
  assign rd    = if_instr[5:3];
  assign funct = if_instr[2:0];
  assign imm   = {{(DW-6){if_instr[5]}}, if_instr[5:0]};

  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  logic [RA-1:0] dec_dest;
  logic          dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_src, dec_branch;
  logic [2:0]    dec_alu_op;
  logic          dec_illegal, uses_rs, uses_rt;

  // Opcode decode into control bits and source-register usage.
  always_comb begin
    dec_dest      = '0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_alu_src   = 1'b0;
    dec_branch    = 1'b0;
    dec_alu_op    = 3'b000;
    dec_illegal   = 1'b0;
    uses_rs       = 1'b0;
    uses_rt       = 1'b0;
    case (op)
      OpRtype: begin
        dec_dest      = rd;
        dec_reg_write = 1'b1;
        dec_alu_op    = funct;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end
      OpAddi: begin
        dec_dest      = rt;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        uses_rs       = 1'b1;
      end
      OpLw: begin
        dec_dest      = rt;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        dec_alu_src   = 1'b1;
        uses_rs       = 1'b1;
      end
      OpSw: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end
      OpBeq: begin
        dec_branch = 1'b1;
        dec_alu_op = 3'b001;
        uses_rs    = 1'b1;
        uses_rt    = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  logic [DW-1:0] opa, opb;

  // Writeback bypass; r0 on operand A always reads as zero.
  always_comb begin
    opa = rf_rdata1;
    opb = rf_rdata2;
    if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == rs)) opa = wb_write_data;
    if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == rt)) opb = wb_write_data;
    if (rs == '0) opa = '0;
  end

  logic hazard, load;

  assign hazard = if_valid && ex_valid && ex_mem_read && (ex_dest != '0) &&
                  ((uses_rs && (ex_dest == rs)) || (uses_rt && (ex_dest == rt)));
  assign stall  = hazard && !flush;
  // Flush, hazard and an empty IF/ID all produce a bubble.
  assign load   = if_valid && !flush && !hazard;

  // ID/EX latch: loads the decoded instruction or clears to a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !load) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rdata1    <= '0;
      ex_rdata2    <= '0;
      ex_imm       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dest      <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_src   <= 1'b0;
      ex_branch    <= 1'b0;
      ex_alu_op    <= 3'b000;
      ex_illegal   <= 1'b0;
    end else begin
      ex_valid     <= 1'b1;
      ex_pc        <= if_pc;
      ex_rdata1    <= opa;
      ex_rdata2    <= opb;
      ex_imm       <= imm;
      ex_rs        <= rs;
      ex_rt        <= rt;
      ex_dest      <= dec_dest;
      ex_reg_write <= dec_reg_write;
      ex_mem_read  <= dec_mem_read;
      ex_mem_write <= dec_mem_write;
      ex_alu_src   <= dec_alu_src;
      ex_branch    <= dec_branch;
      ex_alu_op    <= dec_alu_op;
      ex_illegal   <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, bypass, load-use stall, flush, reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_instr, if_pc;
  logic        flush;
  logic [2:0]  rf_raddr1, rf_raddr2;
  logic [15:0] rf_rdata1, rf_rdata2;
  logic        wb_reg_write;
  logic [2:0]  wb_write_reg;
  logic [15:0] wb_write_data;
  logic        stall, ex_valid;
  logic [15:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [2:0]  ex_rs, ex_rt, ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch;
  logic [2:0]  ex_alu_op;
  logic        ex_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_reg_write(wb_reg_write),
    .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_alu_op(ex_alu_op),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
    #1;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
    rf_rdata1 = '0; rf_rdata2 = '0;
    wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0;
    #12;
    chk("rst_valid", ex_valid, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    step();
    chk("idle_valid", ex_valid, 0);

    // ADDI r1 = r5 + (-1)
    rf_rdata1 = 16'h0010;
    drive(1, 16'h1A7F, 16'h0100);
    chk("raddr1", rf_raddr1, 5);
    chk("raddr2", rf_raddr2, 1);
    step();
    chk("addi_valid", ex_valid, 1);
    chk("addi_dest", ex_dest, 1);
    chk("addi_imm", ex_imm, 16'hFFFF);
    chk("addi_alusrc", ex_alu_src, 1);
    chk("addi_regw", ex_reg_write, 1);
    chk("addi_rdata1", ex_rdata1, 16'h0010);
    chk("addi_pc", ex_pc, 16'h0100);
    chk("addi_memrd", ex_mem_read, 0);

    // R-type rd=4, rs=rt=3, funct=2 with writeback bypass
    rf_rdata1 = 16'h1111; rf_rdata2 = 16'h1111;
    wb_reg_write = 1'b1; wb_write_reg = 3'd3; wb_write_data = 16'hBEEF;
    drive(1, 16'h06E2, 16'h0102);
    step();
    chk("byp_a", ex_rdata1, 16'hBEEF);
    chk("byp_b", ex_rdata2, 16'hBEEF);
    chk("r_dest", ex_dest, 4);
    chk("r_aluop", ex_alu_op, 2);
    wb_write_reg = 3'd0;
    step();
    chk("nobyp_a", ex_rdata1, 16'h1111);
    chk("nobyp_b", ex_rdata2, 16'h1111);
    wb_reg_write = 1'b0;

    // LW r2 then R-type using r2 -> one-cycle stall
    drive(1, 16'h2284, 16'h0104);
    chk("lw_nostall", stall, 0);
    step();
    chk("lw_memrd", ex_mem_read, 1);
    chk("lw_dest", ex_dest, 2);
    drive(1, 16'h0570, 16'h0106);
    chk("lu_stall", stall, 1);
    step();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_bubble_regw", ex_reg_write, 0);
    chk("lu_stall_gone", stall, 0);
    step();
    chk("lu_valid", ex_valid, 1);
    chk("lu_rs", ex_rs, 2);
    chk("lu_dest", ex_dest, 6);
    chk("lu_pc", ex_pc, 16'h0106);

    // LW r2 then ADDI with rt=2 (rs-only user) -> no stall
    drive(1, 16'h2284, 16'h0108);
    step();
    drive(1, 16'h1681, 16'h010A);
    chk("addi_rt_nostall", stall, 0);
    step();
    chk("addi2_valid", ex_valid, 1);
    chk("addi2_dest", ex_dest, 2);

    // Flush together with a load-use hazard
    drive(1, 16'h2284, 16'h010C);
    step();
    flush = 1'b1;
    drive(1, 16'h0570, 16'h010E);
    chk("flush_stall", stall, 0);
    step();
    flush = 1'b0;
    chk("flush_valid", ex_valid, 0);
    chk("flush_regw", ex_reg_write, 0);
    chk("flush_pc", ex_pc, 0);

    // Illegal opcode 7
    drive(1, 16'h7123, 16'h0110);
    step();
    chk("ill_flag", ex_illegal, 1);
    chk("ill_regw", ex_reg_write, 0);
    chk("ill_valid", ex_valid, 1);

    // LW into r0 followed by an r0 user -> no stall; operand A forced to 0
    drive(1, 16'h2204, 16'h0112);
    step();
    chk("lw0_dest", ex_dest, 0);
    drive(1, 16'h0008, 16'h0114);
    chk("r0_nostall", stall, 0);
    step();
    chk("r0_valid", ex_valid, 1);
    chk("r0_opa", ex_rdata1, 0);

    // Reset in the middle of a stall
    drive(1, 16'h2284, 16'h0116);
    step();
    drive(1, 16'h0570, 16'h0118);
    chk("rs_stall_pre", stall, 1);
    rst = 1'b1;
    #1;
    chk("rs_valid", ex_valid, 0);
    chk("rs_memrd", ex_mem_read, 0);
    chk("rs_stall", stall, 0);
    rst = 1'b0;
    step();
    chk("rs_reenter", ex_valid, 1);
    chk("rs_reenter_rs", ex_rs, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 16-bit pipelined core; sits directly upstream of the 8x16 register file and feeds the execute stage.
- Decodes the IF/ID instruction and drives the register-file read addresses.
- Bypasses same-cycle writeback data, detects load-use hazards (stall plus bubble), and registers the ID/EX pipeline latch with flush support.

Parameters:
- DW, 16, datapath and instruction width
- RA, 3, register address width (8 registers, r0 hardwired 0)

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high; clock clk
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  16  instruction word
- if_pc  in  16  PC of if_instr
- flush  in  1  kill the instruction entering ID/EX (taken branch)
- rf_raddr1  out  3  register-file read address 1 (rs)
- rf_raddr2  out  3  register-file read address 2 (rt)
- rf_rdata1  in  16  register-file read data 1
- rf_rdata2  in  16  register-file read data 2
- wb_reg_write  in  1  writeback write enable (same signal the register file sees)
- wb_write_reg  in  3  writeback destination
- wb_write_data  in  16  writeback data
- stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc  out  16  registered PC
- ex_rdata1  out  16  registered operand A
- ex_rdata2  out  16  registered operand B
- ex_imm  out  16  sign-extended imm6
- ex_rs  out  3  registered rs
- ex_rt  out  3  registered rt
- ex_dest  out  3  destination register
- ex_reg_write  out  1  control
- ex_mem_read  out  1  control
- ex_mem_write  out  1  control
- ex_alu_src  out  1  control: 1 = use imm
- ex_branch  out  1  control
- ex_alu_op  out  3  ALU operation
- ex_illegal  out  1  undefined opcode seen

Behaviour:
- Instruction fields: op=[15:12], rs=[11:9], rt=[8:6], rd=[5:3], funct=[2:0], imm6=[5:0] (sign-extended to 16).
- Decode table, listed as op: name, dest, reg_write, mem_read, mem_write, alu_src, branch, alu_op:
  - 0: R-type, dest=rd, 1, 0, 0, 0, 0, funct
  - 1: ADDI, dest=rt, 1, 0, 0, 1, 0, 000
  - 2: LW, dest=rt, 1, 1, 0, 1, 0, 000
  - 3: SW, dest=0, 0, 0, 1, 1, 0, 000
  - 4: BEQ, dest=0, 0, 0, 0, 0, 1, 001 (sub)
  - 5-15: illegal; all controls 0, ex_illegal=1 (if not flushed/stalled).
- Source usage:
  - R-type, SW, BEQ use rs and rt.
  - ADDI and LW use rs only.
  - Illegal uses neither.
- Read addresses: rf_raddr1=rs and rf_raddr2=rt, combinationally, always (even when invalid).
- Bypass (combinational): operand A = wb_write_data if wb_reg_write && wb_write_reg!=0 && wb_write_reg==rs; otherwise rf_rdata1. Operand B is the same with rt. If rs==0, operand A = 0 regardless of any bypass.
- Load-use hazard: hazard = if_valid && ex_valid && ex_mem_read && ex_dest!=0 && ((uses_rs && ex_dest==rs) || (uses_rt && ex_dest==rt)).
- stall = hazard && !flush. It is combinational, so zero latency.
- ID/EX update on every posedge clk, in priority order:
  - flush: bubble.
  - hazard: bubble, and IF/ID is held by upstream via stall.
  - !if_valid: bubble.
  - else: load decoded values, ex_valid=1.
- Bubble definition:
  - ex_valid=0, all control outputs 0, ex_illegal=0.
  - Data/address fields (ex_pc, ex_rdata*, ex_imm, ex_rs, ex_rt, ex_dest) are cleared to 0.
- Latency: 1 cycle from an IF/ID instruction to ex_* outputs.
- Stall is at most one cycle per load-use pair: the next cycle ex_valid=0, so hazard is deasserted.
- Reset: async on rst; all ex_* outputs cleared to 0 (equivalent to a bubble). stall is 0 because ex_valid=0.
- Reset mid-stall: state clears immediately; the held instruction re-enters once upstream releases it.
- Simultaneous flush+hazard: flush wins; stall=0 and a bubble is inserted.

Test Plan:
- Reset: rst=1 mid-operation -> all ex_* = 0 asynchronously, stall=0; after release with if_valid=0 -> ex_valid stays 0.
- Decode: if_instr=0x1A7F (ADDI rs=5, rt=1, imm=-1), rf_rdata1=0x0010 -> next edge ex_valid=1, ex_dest=1, ex_imm=0xFFFF, ex_alu_src=1, ex_reg_write=1, ex_rdata1=0x0010.
- Bypass: R-type rs=3, rt=3 with wb_reg_write=1, wb_write_reg=3, wb_write_data=0xBEEF, rf_rdata=0x1111 -> ex_rdata1=ex_rdata2=0xBEEF. Repeat with wb_write_reg=0 -> 0x1111.
- Load-use: LW r2 then R-type using rs=2 -> stall=1 for exactly one cycle, ex_valid=0 for one cycle, then the R-type latches with ex_rs=2. ADDI r4 (rs=2-free) after LW r2 -> no stall.
- Flush priority: flush=1 together with a load-use hazard -> stall=0, next ex_valid=0, controls 0.
- Illegal/r0: op=0x7 -> ex_illegal=1, ex_reg_write=0. LW with rt=0 followed by a user of r0 -> no stall.
